pc_stack_unit: RTL and testbench



---
 rtl/pc_stack_unit_pkg.sv | 32 +++
 rtl/pc_stack_unit_return_stack.sv | 36 +++
 rtl/pc_stack_unit.sv | 99 +++++++++
 tb/tb_pc_stack_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_stack_unit_pkg.sv
// pc_stack_unit_pkg: shared widths, vectors and the PC operation encoding for pc_stack_unit.
package pc_stack_unit_pkg;

    localparam int PC_W        = 13;
    localparam int STACK_DEPTH = 8;
    localparam int PTR_W       = $clog2(STACK_DEPTH);
    localparam int DEPTH_W     = PTR_W + 1;
    localparam int JADDR_W     = PC_W - 2;

    localparam logic [PC_W-1:0] RESET_VECTOR = 13'h0000;
    localparam logic [PC_W-1:0] INT_VECTOR   = 13'h0004;

    typedef enum logic [2:0] {
        PC_OP_HOLD = 3'd0,
        PC_OP_INCR = 3'd1,
        PC_OP_JUMP = 3'd2,
        PC_OP_CALL = 3'd3,
        PC_OP_RET  = 3'd4,
        PC_OP_INT  = 3'd5
    } pc_op_e;

    // Exactly one winner per cycle so a losing call can never leave a partial push.
    function automatic pc_op_e pc_op_sel(input logic incr, input logic jump, input logic call,
                                         input logic ret, input logic intr);
        return intr ? PC_OP_INT  :
               ret  ? PC_OP_RET  :
               call ? PC_OP_CALL :
               jump ? PC_OP_JUMP :
               incr ? PC_OP_INCR : PC_OP_HOLD;
    endfunction

endpackage

// File: rtl/pc_stack_unit_return_stack.sv
// pc_stack_unit_return_stack: circular PC_W x STACK_DEPTH return stack with a wrapping pointer.
module pc_stack_unit_return_stack
    import pc_stack_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [PC_W-1:0]  push_data_i,
    output logic [PC_W-1:0]  top_o,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PC_W-1:0]  stack_q [STACK_DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Overflow and underflow simply wrap the pointer; the oldest slot gets overwritten.
    always_comb begin
        ptr_d = push_i ? ptr_q + 1'b1 : pop_i ? ptr_q - 1'b1 : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (push_i) stack_q[ptr_q] <= push_data_i;
        end
    end

    assign top_o = stack_q[ptr_q - 1'b1];
    assign ptr_o = ptr_q;

endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter and 8-level return stack sequenced by decoder strobes.
// Define PC_STACK_STATUS_EN to add sticky stack_ovf/stack_unf outputs backed by a depth counter.
module pc_stack_unit
    import pc_stack_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_incr_en,
    input  logic               pc_j_en,
    input  logic               pc_call_en,
    input  logic               pc_ret_en,
    input  logic               pc_int_en,
    input  logic [JADDR_W-1:0] j_addr,
    input  logic [1:0]         pclath_hi,
    output logic [PC_W-1:0]    pc,
    output logic [PTR_W-1:0]   stack_ptr
`ifdef PC_STACK_STATUS_EN
    ,
    output logic               stack_ovf,
    output logic               stack_unf
`endif
);

    pc_op_e           op;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  jump_tgt;
    logic [PC_W-1:0]  ret_tgt;
    logic [PC_W-1:0]  push_data;
    logic             push;
    logic             pop;

    assign op        = pc_op_sel(pc_incr_en, pc_j_en, pc_call_en, pc_ret_en, pc_int_en);
    assign pc_inc    = pc_q + 1'b1;
    assign jump_tgt  = {pclath_hi, j_addr};
    assign push      = (op == PC_OP_CALL) || (op == PC_OP_INT);
    assign pop       = (op == PC_OP_RET);
    // Interrupts save the un-executed instruction; calls save the one after.
    assign push_data = (op == PC_OP_INT) ? pc_q : pc_inc;

    always_comb begin
        pc_d = (op == PC_OP_INT)                          ? INT_VECTOR :
               (op == PC_OP_RET)                          ? ret_tgt    :
               (op == PC_OP_CALL) || (op == PC_OP_JUMP)   ? jump_tgt   :
               (op == PC_OP_INCR)                         ? pc_inc     : pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_VECTOR;
        else     pc_q <= pc_d;
    end

    pc_stack_unit_return_stack u_stack (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (push_data),
        .top_o       (ret_tgt),
        .ptr_o       (stack_ptr)
    );

    assign pc = pc_q;

`ifdef PC_STACK_STATUS_EN
    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;
    logic               ovf_q;
    logic               unf_q;
    logic               full;
    logic               empty;

    assign full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty = (depth_q == '0);

    // Depth saturates so the flags reflect real over/underflow even though the pointer wraps.
    always_comb begin
        depth_d = push ? (full ? depth_q : depth_q + 1'b1) :
                  pop  ? (empty ? depth_q : depth_q - 1'b1) : depth_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_q | (push & full);
            unf_q   <= unf_q | (pop & empty);
        end
    end

    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;
`endif

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: scoreboard bench for pc_stack_unit; a reference model queues expected state per strobe.
module tb_pc_stack_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_incr_en = 1'b0;
    logic        pc_j_en = 1'b0;
    logic        pc_call_en = 1'b0;
    logic        pc_ret_en = 1'b0;
    logic        pc_int_en = 1'b0;
    logic [10:0] j_addr = '0;
    logic [1:0]  pclath_hi = '0;
    logic [12:0] pc;
    logic [2:0]  stack_ptr;
`ifdef PC_STACK_STATUS_EN
    logic        stack_ovf;
    logic        stack_unf;
`endif

    typedef struct packed {
        logic [12:0] pc;
        logic [2:0]  ptr;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        sb [$];
    logic [12:0] m_stk [8];
    logic [12:0] m_pc;
    logic [2:0]  m_ptr;
    logic [3:0]  m_depth;
    logic        m_ovf;
    logic        m_unf;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    pc_stack_unit dut (
        .clk        (clk),
        .rst        (rst),
        .pc_incr_en (pc_incr_en),
        .pc_j_en    (pc_j_en),
        .pc_call_en (pc_call_en),
        .pc_ret_en  (pc_ret_en),
        .pc_int_en  (pc_int_en),
        .j_addr     (j_addr),
        .pclath_hi  (pclath_hi),
        .pc         (pc),
        .stack_ptr  (stack_ptr)
`ifdef PC_STACK_STATUS_EN
        ,
        .stack_ovf  (stack_ovf),
        .stack_unf  (stack_unf)
`endif
    );

    task automatic drive(input logic r, input logic inc, input logic j, input logic c,
                         input logic rt, input logic it, input logic [10:0] ja, input logic [1:0] ph);
        logic [12:0] pushed;
        logic        do_push;
        exp_t        e;
        rst = r; pc_incr_en = inc; pc_j_en = j; pc_call_en = c; pc_ret_en = rt; pc_int_en = it;
        j_addr = ja; pclath_hi = ph;
        do_push = 1'b0;
        pushed = '0;
        if (r) begin
            m_pc = 13'h0000; m_ptr = 3'd0; m_depth = 4'd0; m_ovf = 1'b0; m_unf = 1'b0;
            for (int i = 0; i < 8; i++) m_stk[i] = '0;
        end else if (it) begin
            do_push = 1'b1; pushed = m_pc; m_pc = 13'h0004;
        end else if (rt) begin
            m_ptr = m_ptr - 3'd1;
            m_pc = m_stk[m_ptr];
            if (m_depth == 4'd0) m_unf = 1'b1; else m_depth = m_depth - 4'd1;
        end else if (c) begin
            do_push = 1'b1; pushed = m_pc + 13'd1; m_pc = {ph, ja};
        end else if (j) begin
            m_pc = {ph, ja};
        end else if (inc) begin
            m_pc = m_pc + 13'd1;
        end
        if (do_push) begin
            m_stk[m_ptr] = pushed;
            m_ptr = m_ptr + 3'd1;
            if (m_depth == 4'd8) m_ovf = 1'b1; else m_depth = m_depth + 4'd1;
        end
        e.pc = m_pc; e.ptr = m_ptr; e.ovf = m_ovf; e.unf = m_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 0; pc_incr_en = 0; pc_j_en = 0; pc_call_en = 0; pc_ret_en = 0; pc_int_en = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        drive(1, 0, 0, 0, 0, 0, 11'h0, 2'd0);
        e = sb.pop_front();
        n_checks++;
        if (pc !== e.pc || stack_ptr !== e.ptr)
            $display("FAIL reset: pc=%h ptr=%0d expected pc=%h ptr=%0d", pc, stack_ptr, e.pc, e.ptr);
        else n_pass++;
        n_checks++;
        if (pc !== 13'h0000) $display("FAIL reset_vec: pc=%h expected 0000", pc); else n_pass++;
    endtask

    task automatic test_incr();
        exp_t e;
        for (int i = 1; i <= 3; i++) begin
            drive(0, 1, 0, 0, 0, 0, 11'h0, 2'd0);
            e = sb.pop_front();
            n_checks++;
            if (pc !== e.pc || pc !== 13'(i))
                $display("FAIL incr[%0d]: pc=%h expected %h", i, pc, e.pc);
            else n_pass++;
        end
        drive(0, 1, 1, 0, 0, 0, 11'h7FF, 2'd3);
        e = sb.pop_front();
        n_checks++;
        if (pc !== e.pc || pc !== 13'h1FFF) $display("FAIL jump_max: pc=%h expected 1fff", pc); else n_pass++;
        drive(0, 1, 0, 0, 0, 0, 11'h0, 2'd0);
        e = sb.pop_front();
        n_checks++;
        if (pc !== e.pc || pc !== 13'h0000) $display("FAIL incr_wrap: pc=%h expected 0000", pc); else n_pass++;
    endtask

    task automatic test_call_ret();
        exp_t e;
        drive(0, 0, 1, 0, 0, 0, 11'h010, 2'd0);
        e = sb.pop_front();
        n_checks++;
        if (pc !== e.pc) $display("FAIL call_setup: pc=%h expected %h", pc, e.pc); else n_pass++;
        drive(0, 0, 0, 1, 0, 0, 11'h123, 2'd1);
        e = sb.pop_front();
        n_checks++;
        if (pc !== e.pc || stack_ptr !== e.ptr || pc !== 13'h0923 || stack_ptr !== 3'd1)
            $display("FAIL call: pc=%h ptr=%0d expected pc=0923 ptr=1", pc, stack_ptr);
        else n_pass++;
        drive(0, 0, 0, 0, 1, 0, 11'h0, 2'd0);
        e = sb.pop_front();
        n_checks++;
        if (pc !== e.pc || stack_ptr !== e.ptr || pc !== 13'h0011 || stack_ptr !== 3'd0)
            $display("FAIL ret: pc=%h ptr=%0d expected pc=0011 ptr=0", pc, stack_ptr);
        else n_pass++;
    endtask

    task automatic test_overflow();
        exp_t        e;
        logic [12:0] ret_exp [9] = '{13'h9, 13'h8, 13'h7, 13'h6, 13'h5, 13'h4, 13'h3, 13'h2, 13'h9};
        drive(0, 0, 1, 0, 0, 0, 11'h020, 2'd0);
        void'(sb.pop_front());
        for (int i = 1; i <= 9; i++) begin
            drive(0, 0, 0, 1, 0, 0, 11'(i), 2'd0);
            e = sb.pop_front();
            n_checks++;
            if (pc !== e.pc || stack_ptr !== e.ptr || pc !== 13'(i) || stack_ptr !== 3'(i))
                $display("FAIL nest_call[%0d]: pc=%h ptr=%0d expected pc=%h ptr=%0d", i, pc, stack_ptr, e.pc, e.ptr);
            else n_pass++;
`ifdef PC_STACK_STATUS_EN
            n_checks++;
            if (stack_ovf !== e.ovf || stack_ovf !== (i == 9))
                $display("FAIL ovf[%0d]: stack_ovf=%b expected %b", i, stack_ovf, e.ovf);
            else n_pass++;
`endif
        end
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 0, 0, 1, 0, 11'h0, 2'd0);
            e = sb.pop_front();
            n_checks++;
            if (pc !== e.pc || stack_ptr !== e.ptr || pc !== ret_exp[i])
                $display("FAIL nest_ret[%0d]: pc=%h ptr=%0d expected pc=%h ptr=%0d", i, pc, stack_ptr, ret_exp[i], e.ptr);
            else n_pass++;
`ifdef PC_STACK_STATUS_EN
            n_checks++;
            if (stack_unf !== e.unf || stack_unf !== (i == 8))
                $display("FAIL unf[%0d]: stack_unf=%b expected %b", i, stack_unf, e.unf);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_int_priority();
        exp_t e;
        drive(0, 0, 1, 0, 0, 0, 11'h050, 2'd0);
        void'(sb.pop_front());
        drive(0, 1, 0, 1, 0, 1, 11'h1AA, 2'd2);
        e = sb.pop_front();
        n_checks++;
        if (pc !== e.pc || stack_ptr !== e.ptr || pc !== 13'h0004 || stack_ptr !== 3'd1)
            $display("FAIL int_entry: pc=%h ptr=%0d expected pc=0004 ptr=1", pc, stack_ptr);
        else n_pass++;
        drive(0, 0, 0, 0, 1, 0, 11'h0, 2'd0);
        e = sb.pop_front();
        n_checks++;
        if (pc !== e.pc || stack_ptr !== e.ptr || pc !== 13'h0050 || stack_ptr !== 3'd0)
            $display("FAIL int_ret: pc=%h ptr=%0d expected pc=0050 ptr=0", pc, stack_ptr);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        drive(0, 0, 0, 1, 0, 0, 11'h100, 2'd0);
        void'(sb.pop_front());
        drive(0, 0, 0, 1, 0, 0, 11'h200, 2'd0);
        void'(sb.pop_front());
        drive(1, 0, 0, 1, 0, 0, 11'h300, 2'd1);
        e = sb.pop_front();
        n_checks++;
        if (pc !== e.pc || stack_ptr !== e.ptr || pc !== 13'h0 || stack_ptr !== 3'd0)
            $display("FAIL rst_mid: pc=%h ptr=%0d expected pc=0000 ptr=0", pc, stack_ptr);
        else n_pass++;
`ifdef PC_STACK_STATUS_EN
        n_checks++;
        if (stack_ovf !== 1'b0 || stack_unf !== 1'b0)
            $display("FAIL rst_flags: ovf=%b unf=%b expected 0 0", stack_ovf, stack_unf);
        else n_pass++;
`endif
        drive(0, 0, 0, 0, 1, 0, 11'h0, 2'd0);
        e = sb.pop_front();
        n_checks++;
        if (pc !== e.pc || stack_ptr !== e.ptr || pc !== 13'h0 || stack_ptr !== 3'd7)
            $display("FAIL rst_cleared_ret: pc=%h ptr=%0d expected pc=0000 ptr=7", pc, stack_ptr);
        else n_pass++;
    endtask

    task automatic test_idle();
        exp_t e;
        drive(0, 0, 1, 0, 0, 0, 11'h3AB, 2'd2);
        void'(sb.pop_front());
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, 0, 11'h555, 2'd1);
            e = sb.pop_front();
            n_checks++;
            if (pc !== e.pc || stack_ptr !== e.ptr || pc !== 13'h13AB || stack_ptr !== 3'd7)
                $display("FAIL idle[%0d]: pc=%h ptr=%0d expected pc=13ab ptr=7", i, pc, stack_ptr);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        drive(0, 0, 0, 1, 0, 0, 11'h040, 2'd0);
        drive(0, 0, 0, 1, 0, 0, 11'h080, 2'd0);
        drive(0, 0, 0, 0, 1, 0, 11'h0, 2'd0);
        drive(0, 0, 0, 0, 1, 0, 11'h0, 2'd0);
        e = sb.pop_back();
        n_checks++;
        if (pc !== e.pc || stack_ptr !== e.ptr || pc !== 13'h13AC || stack_ptr !== 3'd7)
            $display("FAIL b2b: pc=%h ptr=%0d expected pc=13ac ptr=7", pc, stack_ptr);
        else n_pass++;
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_incr();
        test_call_ret();
        test_overflow();
        test_int_priority();
        test_reset_mid();
        test_idle();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
